h12_hour_setter: RTL and testbench

- Sequential hour-setting unit for the 12-hour display mode; the reverse direction of the 24h→12h converters.
- On an edit request it loads the running 24h BCD hour and shows it as 12h BCD plus nAM_PM.
- While editing, it steps the hour with inc/dec buttons (with auto-repeat) and toggles AM/PM.
- On commit it converts the 12h value back to 24h BCD and hands it to the timekeeping core with a one-cycle valid strobe.

---
 rtl/h12_hour_setter.sv | 187 ++++++++++++++++++
 tb/tb_h12_hour_setter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/h12_hour_setter.sv
// rtl/h12_hour_setter.sv - 12-hour mode hour editor: load 24h BCD, step/toggle in 12h, commit back to 24h
module h12_hour_setter #(
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       edit_start,
  input  logic [5:0] hour24_in,
  input  logic       inc,
  input  logic       dec,
  input  logic       toggle_ampm,
  input  logic       commit,
  input  logic       cancel,
  output logic [4:0] hour12,
  output logic       nAM_PM,
  output logic       editing,
  output logic [5:0] hour24_out,
  output logic       hour24_valid,
  output logic       load_err
);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_CONV} state_t;

  localparam logic [15:0] DELAY_C = 16'(REPEAT_DELAY);
  localparam logic [15:0] RATE_C  = (REPEAT_RATE < 1) ? 16'd1 : 16'(REPEAT_RATE);
  localparam bit          REP_EN  = (REPEAT_DELAY != 0);

  function automatic logic [4:0] bcd_to_bin(input logic [5:0] b);
    return 5'(b[5:4]) * 5'd10 + 5'(b[3:0]);
  endfunction

  function automatic logic [5:0] bin_to_bcd(input logic [4:0] v);
    if (v >= 5'd20)      return {2'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) return {2'd1, 4'(v - 5'd10)};
    else                 return {2'd0, v[3:0]};
  endfunction

  state_t      r_state;
  logic [4:0]  r_hour12;
  logic        r_nampm;
  logic        r_editing;
  logic [5:0]  r_hour24_out;
  logic        r_valid;
  logic        r_load_err;
  logic        r_inc_prev, r_dec_prev;
  logic        r_inc_rep, r_dec_rep;
  logic [15:0] r_inc_cnt, r_dec_cnt;

  logic       w_in_valid, w_load_pm;
  logic [4:0] w_in_bin, w_load_bin12, w_load_h12;
  logic [4:0] w_h12_bin, w_out_bin;
  logic [5:0] w_out_bcd;
  logic [4:0] w_up_h12, w_dn_h12;
  logic       w_up_flip, w_dn_flip;
  logic       w_inc_rep, w_dec_rep, w_inc_fire, w_dec_fire;

  // Load path: 24h BCD -> 12h BCD plus PM flag
  assign w_in_valid   = (hour24_in[3:0] <= 4'd9) && (hour24_in <= 6'h23);
  assign w_in_bin     = bcd_to_bin(hour24_in);
  assign w_load_pm    = (w_in_bin >= 5'd12);
  assign w_load_bin12 = (w_in_bin == 5'd0)  ? 5'd12 :
                        (w_in_bin > 5'd12)  ? (w_in_bin - 5'd12) : w_in_bin;
  assign w_load_h12   = 5'(bin_to_bcd(w_load_bin12));

  // Commit path: 12h + PM flag -> 24h BCD
  assign w_h12_bin = bcd_to_bin({1'b0, r_hour12});
  assign w_out_bin = !r_nampm ? ((w_h12_bin == 5'd12) ? 5'd0 : w_h12_bin)
                              : ((w_h12_bin == 5'd12) ? 5'd12 : (w_h12_bin + 5'd12));
  assign w_out_bcd = bin_to_bcd(w_out_bin);

  always_comb begin
    w_up_h12  = r_hour12 + 5'd1;
    w_up_flip = (r_hour12 == 5'h11);
    if (r_hour12 == 5'h12)      w_up_h12 = 5'h01;
    else if (r_hour12 == 5'h09) w_up_h12 = 5'h10;
    w_dn_h12  = r_hour12 - 5'd1;
    w_dn_flip = (r_hour12 == 5'h12);
    if (r_hour12 == 5'h01)      w_dn_h12 = 5'h12;
    else if (r_hour12 == 5'h10) w_dn_h12 = 5'h09;
  end

  // A step fires on a fresh press, or when the hold counter reaches the delay/rate mark
  assign w_inc_rep  = REP_EN && inc && r_inc_prev &&
                      (r_inc_rep ? (r_inc_cnt == RATE_C) : (r_inc_cnt == DELAY_C));
  assign w_dec_rep  = REP_EN && dec && r_dec_prev &&
                      (r_dec_rep ? (r_dec_cnt == RATE_C) : (r_dec_cnt == DELAY_C));
  assign w_inc_fire = !dec && ((inc && !r_inc_prev) || w_inc_rep);
  assign w_dec_fire = !inc && ((dec && !r_dec_prev) || w_dec_rep);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_inc_cnt <= '0;
      r_dec_cnt <= '0;
      r_inc_rep <= 1'b0;
      r_dec_rep <= 1'b0;
    end else begin
      if (r_state != S_EDIT || !inc || dec) begin
        r_inc_cnt <= '0;
        r_inc_rep <= 1'b0;
      end else if (!r_inc_prev) begin
        r_inc_cnt <= 16'd1;
        r_inc_rep <= 1'b0;
      end else if (w_inc_rep) begin
        r_inc_cnt <= 16'd1;
        r_inc_rep <= 1'b1;
      end else if (r_inc_cnt != '1) begin
        r_inc_cnt <= r_inc_cnt + 16'd1;
      end
      if (r_state != S_EDIT || !dec || inc) begin
        r_dec_cnt <= '0;
        r_dec_rep <= 1'b0;
      end else if (!r_dec_prev) begin
        r_dec_cnt <= 16'd1;
        r_dec_rep <= 1'b0;
      end else if (w_dec_rep) begin
        r_dec_cnt <= 16'd1;
        r_dec_rep <= 1'b1;
      end else if (r_dec_cnt != '1) begin
        r_dec_cnt <= r_dec_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_hour12     <= 5'h12;
      r_nampm      <= 1'b0;
      r_editing    <= 1'b0;
      r_hour24_out <= 6'h00;
      r_valid      <= 1'b0;
      r_load_err   <= 1'b0;
      r_inc_prev   <= 1'b0;
      r_dec_prev   <= 1'b0;
    end else begin
      r_inc_prev <= inc;
      r_dec_prev <= dec;
      r_valid    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (edit_start) begin
            r_state    <= S_EDIT;
            r_editing  <= 1'b1;
            r_hour12   <= w_in_valid ? w_load_h12 : 5'h12;
            r_nampm    <= w_in_valid ? w_load_pm : 1'b0;
            r_load_err <= !w_in_valid;
          end
        end
        S_EDIT: begin
          if (cancel) begin
            r_state   <= S_IDLE;
            r_editing <= 1'b0;
          end else if (commit) begin
            r_state   <= S_CONV;
            r_editing <= 1'b0;
          end else if (toggle_ampm) begin
            r_nampm <= !r_nampm;
          end else if (w_inc_fire) begin
            r_hour12 <= w_up_h12;
            r_nampm  <= r_nampm ^ w_up_flip;
          end else if (w_dec_fire) begin
            r_hour12 <= w_dn_h12;
            r_nampm  <= r_nampm ^ w_dn_flip;
          end
        end
        S_CONV: begin
          r_hour24_out <= w_out_bcd;
          r_valid      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_editing <= 1'b0;
        end
      endcase
    end
  end

  assign hour12       = r_hour12;
  assign nAM_PM       = r_nampm;
  assign editing      = r_editing;
  assign hour24_out   = r_hour24_out;
  assign hour24_valid = r_valid;
  assign load_err     = r_load_err;

endmodule

// File: tb/tb_h12_hour_setter.sv
// tb/tb_h12_hour_setter.sv - directed scoreboard bench for h12_hour_setter
module tb_h12_hour_setter;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       edit_start = 1'b0, inc = 1'b0, dec = 1'b0;
  logic       toggle_ampm = 1'b0, commit = 1'b0, cancel = 1'b0;
  logic [5:0] hour24_in = 6'h00;
  logic [4:0] hour12;
  logic       nAM_PM, editing, hour24_valid, load_err;
  logic [5:0] hour24_out;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  h12_hour_setter #(.REPEAT_DELAY(16), .REPEAT_RATE(4)) dut (
    .clk(clk), .nrst(nrst), .edit_start(edit_start), .hour24_in(hour24_in),
    .inc(inc), .dec(dec), .toggle_ampm(toggle_ampm), .commit(commit), .cancel(cancel),
    .hour12(hour12), .nAM_PM(nAM_PM), .editing(editing), .hour24_out(hour24_out),
    .hour24_valid(hour24_valid), .load_err(load_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] model_12(input int b);
    int h;
    h = (b % 12 == 0) ? 12 : (b % 12);
    return {1'b0, (b >= 12)} << 5 | 6'((h / 10) * 16 + (h % 10));
  endfunction

  task automatic load(input logic [5:0] h);
    hour24_in  = h;
    edit_start = 1'b1;
    @(negedge clk);
    edit_start = 1'b0;
  endtask

  task automatic pulse_inc();
    inc = 1'b1; @(negedge clk); inc = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_dec();
    dec = 1'b1; @(negedge clk); dec = 1'b0; @(negedge clk);
  endtask

  task automatic do_cancel();
    cancel = 1'b1; @(negedge clk); cancel = 1'b0;
  endtask

  task automatic commit_check(input string tag, input logic [5:0] expv);
    logic [5:0] e;
    exp_q.push_back(expv);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk({tag, "_valid_early"}, {7'd0, hour24_valid}, 8'd0);
    chk({tag, "_editing_conv"}, {7'd0, editing}, 8'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {7'd0, hour24_valid}, 8'd1);
    e = exp_q.pop_front();
    chk({tag, "_hour24"}, {2'd0, hour24_out}, {2'd0, e});
    @(negedge clk);
    chk({tag, "_valid_off"}, {7'd0, hour24_valid}, 8'd0);
  endtask

  initial begin
    logic [5:0] m;
    logic [5:0] h;
    @(negedge clk); @(negedge clk);
    chk("rst_hour12", {3'd0, hour12}, 8'h12);
    chk("rst_ampm", {7'd0, nAM_PM}, 8'd0);
    chk("rst_h24", {2'd0, hour24_out}, 8'h00);
    chk("rst_valid", {7'd0, hour24_valid}, 8'd0);
    nrst = 1'b1;
    @(negedge clk);

    load(6'h00);
    chk("ld00_hour12", {3'd0, hour12}, 8'h12);
    chk("ld00_ampm", {7'd0, nAM_PM}, 8'd0);
    chk("ld00_editing", {7'd0, editing}, 8'd1);
    do_cancel();
    @(negedge clk);

    for (int b = 0; b < 24; b++) begin
      h = 6'((b / 10) * 16 + (b % 10));
      m = model_12(b);
      load(h);
      chk($sformatf("rt%0d_hour12", b), {3'd0, hour12}, {3'd0, m[4:0]});
      chk($sformatf("rt%0d_ampm", b), {7'd0, nAM_PM}, {7'd0, m[5]});
      commit_check($sformatf("rt%0d", b), h);
    end

    load(6'h10);
    pulse_inc(); pulse_inc();
    chk("step_up_hour12", {3'd0, hour12}, 8'h12);
    chk("step_up_ampm", {7'd0, nAM_PM}, 8'd1);
    commit_check("step_up", 6'h12);
    load(6'h00);
    pulse_dec();
    chk("step_dn_hour12", {3'd0, hour12}, 8'h11);
    chk("step_dn_ampm", {7'd0, nAM_PM}, 8'd1);
    commit_check("step_dn", 6'h23);

    load(6'h01);
    inc = 1'b1;
    repeat (30) @(negedge clk);
    inc = 1'b0;
    @(negedge clk);
    chk("rep_hour12", {3'd0, hour12}, 8'h06);
    chk("rep_ampm", {7'd0, nAM_PM}, 8'd0);
    inc = 1'b1; dec = 1'b1;
    repeat (25) @(negedge clk);
    inc = 1'b0; dec = 1'b0;
    @(negedge clk);
    chk("both_hour12", {3'd0, hour12}, 8'h06);
    load(6'h20);
    chk("ign_start_hour12", {3'd0, hour12}, 8'h06);
    do_cancel();
    @(negedge clk);

    load(6'h05);
    toggle_ampm = 1'b1; @(negedge clk); toggle_ampm = 1'b0;
    chk("tog_ampm", {7'd0, nAM_PM}, 8'd1);
    commit_check("tog", 6'h17);

    load(6'h08);
    commit = 1'b1; cancel = 1'b1;
    @(negedge clk);
    commit = 1'b0; cancel = 1'b0;
    chk("cc_editing", {7'd0, editing}, 8'd0);
    chk("cc_valid0", {7'd0, hour24_valid}, 8'd0);
    @(negedge clk);
    chk("cc_valid1", {7'd0, hour24_valid}, 8'd0);
    chk("cc_h24", {2'd0, hour24_out}, 8'h17);

    load(6'h03);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    nrst = 1'b0;
    #1;
    chk("abort_hour12", {3'd0, hour12}, 8'h12);
    chk("abort_h24", {2'd0, hour24_out}, 8'h00);
    @(negedge clk);
    chk("abort_valid", {7'd0, hour24_valid}, 8'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("abort_valid_post", {7'd0, hour24_valid}, 8'd0);
    chk("abort_editing", {7'd0, editing}, 8'd0);

    load(6'h1A);
    chk("bad1A_hour12", {3'd0, hour12}, 8'h12);
    chk("bad1A_ampm", {7'd0, nAM_PM}, 8'd0);
    chk("bad1A_err", {7'd0, load_err}, 8'd1);
    do_cancel();
    load(6'h24);
    chk("bad24_hour12", {3'd0, hour12}, 8'h12);
    chk("bad24_err", {7'd0, load_err}, 8'd1);
    do_cancel();
    load(6'h07);
    chk("ok07_err", {7'd0, load_err}, 8'd0);
    chk("ok07_hour12", {3'd0, hour12}, 8'h07);
    commit_check("ok07", 6'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
